// File: rtl/vc_arb_pkg.sv
// ---------------------------------------------------------------------------
// vc_arb_pkg
// Shared definitions for the virtual-channel arbiter controller:
//   - FSM state encodings (3-bit, values visible on the state output)
//   - default packet width and destination-select bit
//   - state decode struct plus helper that derives the per-state outputs
// ---------------------------------------------------------------------------
package vc_arb_pkg;

  localparam int STATE_W        = 3;
  localparam int DATA_WIDTH_DEF = 6;
  localparam int DEST_BIT_DEF   = 4;

  localparam logic [2:0] ST_RESET  = 3'd0;
  localparam logic [2:0] ST_INIT   = 3'd1;
  localparam logic [2:0] ST_IDLE   = 3'd2;
  localparam logic [2:0] ST_ACTIVE = 3'd3;
  localparam logic [2:0] ST_ERROR  = 3'd4;

  // Per-state output decodes. fifo_init is low in RESET and INIT so the
  // FIFOs stay cleared until configuration has finished.
  typedef struct packed {
    logic idle;
    logic active;
    logic error;
    logic fifo_init;
  } state_dec_t;

  function automatic state_dec_t decode_state(input logic [2:0] s);
    state_dec_t d;
    d = '0;
    case (s)
      ST_IDLE: begin
        d.idle      = 1'b1;
        d.fifo_init = 1'b1;
      end
      ST_ACTIVE: begin
        d.active    = 1'b1;
        d.fifo_init = 1'b1;
      end
      ST_ERROR: begin
        d.error     = 1'b1;
        d.fifo_init = 1'b1;
      end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/vc_arbiter_ctrl_arb_fsm.sv
// ---------------------------------------------------------------------------
// arb_fsm
// State register and next-state logic of the VC arbiter controller.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   RESET  | held by reset_L; leaves for INIT on the first clock
//   INIT   | configuration: FIFOs cleared, thresholds tracking inputs
//   IDLE   | configured, both source VCs empty
//   ACTIVE | moving packets from VC0/VC1 to D0/D1
//   ERROR  | any error flag seen; frozen until reset_L
//
// Ports
//   clk          rising-edge clock
//   reset_L      asynchronous active-low reset (forces RESET)
//   init         configuration request
//   err_any      OR of all error flags
//   src_pending  at least one source VC non-empty
//   in_flight    a pop from the previous cycle is in its push cycle
//   state        current state (encodings in vc_arb_pkg)
// ---------------------------------------------------------------------------
module arb_fsm
  import vc_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset_L,
  input  logic       init,
  input  logic       err_any,
  input  logic       src_pending,
  input  logic       in_flight,
  output logic [2:0] state
);

  logic [2:0] state_q;
  logic [2:0] state_nxt;

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_RESET: state_nxt = ST_INIT;
      ST_INIT: begin
        if (!init) state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (err_any)          state_nxt = ST_ERROR;
        else if (init)        state_nxt = ST_INIT;
        else if (src_pending) state_nxt = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        // Stay until the last popped packet has had its push cycle.
        if (err_any)                        state_nxt = ST_ERROR;
        else if (init)                      state_nxt = ST_INIT;
        else if (!src_pending && !in_flight) state_nxt = ST_IDLE;
      end
      ST_ERROR: state_nxt = ST_ERROR;
      // Unused encodings recover through the normal configuration path.
      default:  state_nxt = ST_RESET;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) state_q <= ST_RESET;
    else          state_q <= state_nxt;
  end

  assign state = state_q;

endmodule

// File: rtl/vc_arbiter_ctrl.sv
// ---------------------------------------------------------------------------
// vc_arbiter_ctrl
// Moves packets from two source virtual-channel FIFOs (VC0, VC1) to two
// destination FIFOs (D0, D1). VC0 has strict priority over VC1. A popped
// packet appears on the FIFO read data one cycle later and is pushed to
// D0 or D1 in that cycle, chosen by data bit DEST_BIT.
//
// Ports
//   clk, reset_L                  clock, asynchronous active-low reset
//   init                          configuration request (holds INIT)
//   umbral_vc_in, umbral_d_in     thresholds latched while in INIT
//   empty_vc0, empty_vc1          source FIFO empty flags
//   almost_full_d0/d1, full_d0/d1 destination FIFO flags
//   error_in                      error flags {D1, D0, VC1, VC0}
//   data_vc0, data_vc1            source FIFO read data
//   pop_vc0, pop_vc1              source FIFO read enables
//   push_d0, push_d1              destination FIFO write enables
//   data_out                      write data to both D FIFOs (0 when idle)
//   fifo_init                     init for all FIFOs (low clears them)
//   umbral_vc, umbral_d           latched thresholds
//   state, idle, active, error_out current state and its decodes
// ---------------------------------------------------------------------------
module vc_arbiter_ctrl
  import vc_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEST_BIT   = DEST_BIT_DEF
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  init,
  input  logic [3:0]            umbral_vc_in,
  input  logic [3:0]            umbral_d_in,
  input  logic                  empty_vc0,
  input  logic                  empty_vc1,
  input  logic                  almost_full_d0,
  input  logic                  almost_full_d1,
  input  logic                  full_d0,
  input  logic                  full_d1,
  input  logic [3:0]            error_in,
  input  logic [DATA_WIDTH-1:0] data_vc0,
  input  logic [DATA_WIDTH-1:0] data_vc1,
  output logic                  pop_vc0,
  output logic                  pop_vc1,
  output logic                  push_d0,
  output logic                  push_d1,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  fifo_init,
  output logic [3:0]            umbral_vc,
  output logic [3:0]            umbral_d,
  output logic [2:0]            state,
  output logic                  idle,
  output logic                  active,
  output logic                  error_out
);

  logic                  err_any;
  logic                  src_pending;
  logic                  pop_ok;
  logic                  valid_q;
  logic                  sel_q;
  logic                  push_valid;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [3:0]            umbral_vc_q;
  logic [3:0]            umbral_d_q;
  state_dec_t            dec;

  assign err_any     = |error_in;
  assign src_pending = ~empty_vc0 | ~empty_vc1;

  arb_fsm u_fsm (
    .clk         (clk),
    .reset_L     (reset_L),
    .init        (init),
    .err_any     (err_any),
    .src_pending (src_pending),
    .in_flight   (valid_q),
    .state       (state)
  );

  assign dec       = decode_state(state);
  assign idle      = dec.idle;
  assign active    = dec.active;
  assign error_out = dec.error;
  assign fifo_init = dec.fifo_init;

  // Any destination near full, an error, or a configuration request stops
  // new pops immediately; packets already popped still complete.
  assign pop_ok = dec.active & ~almost_full_d0 & ~almost_full_d1 &
                  ~full_d0 & ~full_d1 & ~err_any & ~init;

  assign pop_vc0 = pop_ok & ~empty_vc0;
  assign pop_vc1 = pop_ok & ~empty_vc1 & empty_vc0;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      valid_q <= 1'b0;
      sel_q   <= 1'b0;
    end else begin
      valid_q <= pop_vc0 | pop_vc1;
      sel_q   <= pop_vc1;
    end
  end

  // Thresholds follow the inputs for the whole INIT stay and freeze on exit.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      umbral_vc_q <= '0;
      umbral_d_q  <= '0;
    end else if (state == ST_INIT) begin
      umbral_vc_q <= umbral_vc_in;
      umbral_d_q  <= umbral_d_in;
    end
  end

  assign umbral_vc = umbral_vc_q;
  assign umbral_d  = umbral_d_q;

  // A packet whose push cycle falls outside ACTIVE is dropped.
  assign push_valid = valid_q & dec.active;
  assign rd_data    = sel_q ? data_vc1 : data_vc0;
  assign data_out   = push_valid ? rd_data : '0;
  assign push_d0    = push_valid & ~rd_data[DEST_BIT];
  assign push_d1    = push_valid &  rd_data[DEST_BIT];

endmodule

// File: tb/tb_vc_arbiter_ctrl.sv
module tb_vc_arbiter_ctrl;

  localparam int DW = 6;

  localparam logic [2:0] S_RESET  = 3'd0;
  localparam logic [2:0] S_INIT   = 3'd1;
  localparam logic [2:0] S_IDLE   = 3'd2;
  localparam logic [2:0] S_ACTIVE = 3'd3;
  localparam logic [2:0] S_ERROR  = 3'd4;

  logic          clk = 1'b0;
  logic          reset_L;
  logic          init;
  logic [3:0]    umbral_vc_in, umbral_d_in;
  logic          empty_vc0, empty_vc1;
  logic          almost_full_d0, almost_full_d1, full_d0, full_d1;
  logic [3:0]    error_in;
  logic [DW-1:0] data_vc0, data_vc1;
  logic          pop_vc0, pop_vc1, push_d0, push_d1;
  logic [DW-1:0] data_out;
  logic          fifo_init;
  logic [3:0]    umbral_vc, umbral_d;
  logic [2:0]    state;
  logic          idle, active, error_out;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] vc0_q[$];
  logic [DW-1:0] vc1_q[$];
  logic [DW:0]   exp_q[$];   // {dest, data}
  logic          last_pop0, last_pop1;

  always #5 clk = ~clk;

  vc_arbiter_ctrl #(.DATA_WIDTH(DW), .DEST_BIT(4)) dut (
    .clk            (clk),
    .reset_L        (reset_L),
    .init           (init),
    .umbral_vc_in   (umbral_vc_in),
    .umbral_d_in    (umbral_d_in),
    .empty_vc0      (empty_vc0),
    .empty_vc1      (empty_vc1),
    .almost_full_d0 (almost_full_d0),
    .almost_full_d1 (almost_full_d1),
    .full_d0        (full_d0),
    .full_d1        (full_d1),
    .error_in       (error_in),
    .data_vc0       (data_vc0),
    .data_vc1       (data_vc1),
    .pop_vc0        (pop_vc0),
    .pop_vc1        (pop_vc1),
    .push_d0        (push_d0),
    .push_d1        (push_d1),
    .data_out       (data_out),
    .fifo_init      (fifo_init),
    .umbral_vc      (umbral_vc),
    .umbral_d       (umbral_d),
    .state          (state),
    .idle           (idle),
    .active         (active),
    .error_out      (error_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic refresh_flags();
    empty_vc0 = (vc0_q.size() == 0);
    empty_vc1 = (vc1_q.size() == 0);
  endtask

  // Called at a falling edge with inputs already set. Models the source
  // FIFOs (read data valid after the popping edge) and scores every push.
  task automatic cycle();
    logic p0, p1;
    logic [DW:0] e;
    #1;
    p0 = pop_vc0;
    p1 = pop_vc1;
    last_pop0 = p0;
    last_pop1 = p1;
    @(posedge clk);
    #1;
    if (p0 && vc0_q.size() > 0) data_vc0 = vc0_q.pop_front();
    if (p1 && vc1_q.size() > 0) data_vc1 = vc1_q.pop_front();
    refresh_flags();
    @(negedge clk);
    if (pop_vc0 || pop_vc1) check("pop_exclusive", pop_vc0 & pop_vc1, 0);
    if (push_d0 || push_d1) begin
      if (exp_q.size() == 0) begin
        check("push_unexpected", {push_d1, push_d0}, 0);
      end else begin
        e = exp_q.pop_front();
        check("push_d1", push_d1, e[DW]);
        check("push_d0", push_d0, !e[DW]);
        check("push_data", data_out, e[DW-1:0]);
      end
    end else begin
      check("data_out_nopush", data_out, 0);
    end
  endtask

  task automatic run_until_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (state !== S_IDLE && n < budget) begin
      cycle();
      n++;
    end
    check(tag, state, S_IDLE);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_L = 1'b1;
    init = 1'b0;
    umbral_vc_in = 4'd0;
    umbral_d_in = 4'd0;
    almost_full_d0 = 1'b0;
    almost_full_d1 = 1'b0;
    full_d0 = 1'b0;
    full_d1 = 1'b0;
    error_in = 4'd0;
    data_vc0 = '0;
    data_vc1 = '0;
    refresh_flags();
    #1 reset_L = 1'b0;
    #1;
    check("rst_state", state, S_RESET);
    check("rst_fifo_init", fifo_init, 0);
    check("rst_umbral_vc", umbral_vc, 0);
    check("rst_umbral_d", umbral_d, 0);
    check("rst_pop_push", {pop_vc0, pop_vc1, push_d0, push_d1}, 0);
    check("rst_data_out", data_out, 0);
    check("rst_decodes", {idle, active, error_out}, 0);

    // Configuration sequence
    init = 1'b1;
    umbral_vc_in = 4'd2;
    umbral_d_in = 4'd3;
    repeat (2) @(negedge clk);
    reset_L = 1'b1;
    #1 check("cfg_still_reset", state, S_RESET);
    @(negedge clk);
    cycle();
    check("cfg_init_state", state, S_INIT);
    check("cfg_init_fifo_init", fifo_init, 0);
    cycle();
    check("cfg_init_hold", state, S_INIT);
    check("cfg_umbral_vc", umbral_vc, 2);
    check("cfg_umbral_d", umbral_d, 3);
    init = 1'b0;
    cycle();
    check("cfg_idle_state", state, S_IDLE);
    check("cfg_idle_flag", idle, 1);
    check("cfg_idle_fifo_init", fifo_init, 1);
    umbral_vc_in = 4'd9;
    umbral_d_in = 4'd12;
    cycle();
    check("cfg_umbral_vc_held", umbral_vc, 2);
    check("cfg_umbral_d_held", umbral_d, 3);

    // VC0 holds 0x05 (to D0) then 0x15 (to D1)
    vc0_q = '{6'h05, 6'h15};
    exp_q.push_back({1'b0, 6'h05});
    exp_q.push_back({1'b1, 6'h15});
    refresh_flags();
    cycle();
    check("two_active", state, S_ACTIVE);
    check("two_active_flag", active, 1);
    check("two_pop0_first", pop_vc0, 1);
    check("two_no_push_yet", {push_d0, push_d1}, 0);
    cycle();
    check("two_push0_lat1", push_d0, 1);
    check("two_pop0_second", pop_vc0, 1);
    cycle();
    check("two_push1_lat1", push_d1, 1);
    check("two_pop_done", pop_vc0, 0);
    run_until_idle("two_back_idle", 10);
    check("two_scoreboard_empty", exp_q.size(), 0);

    // Both VCs loaded: VC0 drains first
    vc0_q = '{6'h01, 6'h02};
    vc1_q = '{6'h11, 6'h03};
    exp_q.push_back({1'b0, 6'h01});
    exp_q.push_back({1'b0, 6'h02});
    exp_q.push_back({1'b1, 6'h11});
    exp_q.push_back({1'b0, 6'h03});
    refresh_flags();
    cycle();
    check("prio_pop0", pop_vc0, 1);
    check("prio_no_pop1", pop_vc1, 0);
    run_until_idle("prio_back_idle", 20);
    check("prio_scoreboard_empty", exp_q.size(), 0);

    // Destination backpressure
    almost_full_d1 = 1'b1;
    vc0_q = '{6'h1A, 6'h0B};
    exp_q.push_back({1'b1, 6'h1A});
    exp_q.push_back({1'b0, 6'h0B});
    refresh_flags();
    cycle();
    check("bp_active", state, S_ACTIVE);
    check("bp_no_pop_a", {pop_vc0, pop_vc1}, 0);
    cycle();
    check("bp_no_pop_b", {pop_vc0, pop_vc1}, 0);
    check("bp_still_active", state, S_ACTIVE);
    almost_full_d1 = 1'b0;
    cycle();
    check("bp_resume", last_pop0, 1);
    run_until_idle("bp_back_idle", 10);
    check("bp_scoreboard_empty", exp_q.size(), 0);

    // Error while streaming
    vc0_q = '{6'h01, 6'h02, 6'h03, 6'h04};
    exp_q.push_back({1'b0, 6'h01});
    refresh_flags();
    cycle();
    cycle();
    error_in = 4'b0100;
    #1 check("err_pop_blocked", pop_vc0, 0);
    cycle();
    check("err_state", state, S_ERROR);
    check("err_flag", error_out, 1);
    check("err_no_push", {push_d0, push_d1}, 0);
    check("err_no_pop", {pop_vc0, pop_vc1}, 0);
    check("err_fifo_init", fifo_init, 1);
    check("err_umbral_held", {umbral_vc, umbral_d}, 8'h23);
    error_in = 4'd0;
    repeat (3) cycle();
    check("err_sticky", state, S_ERROR);
    check("err_flag_sticky", error_out, 1);
    check("err_scoreboard_empty", exp_q.size(), 0);

    // Reset out of ERROR, reconfigure, then reset mid-ACTIVE
    reset_L = 1'b0;
    #1;
    check("err_reset_state", state, S_RESET);
    check("err_reset_flag", error_out, 0);
    vc0_q.delete();
    refresh_flags();
    init = 1'b1;
    umbral_vc_in = 4'd5;
    umbral_d_in = 4'd6;
    @(negedge clk);
    reset_L = 1'b1;
    cycle();
    init = 1'b0;
    cycle();
    check("re_idle", state, S_IDLE);
    check("re_umbral", {umbral_vc, umbral_d}, 8'h56);
    vc0_q = '{6'h07, 6'h08, 6'h09};
    exp_q.push_back({1'b0, 6'h07});
    exp_q.push_back({1'b0, 6'h08});
    exp_q.push_back({1'b0, 6'h09});
    refresh_flags();
    cycle();
    cycle();
    check("mid_active", state, S_ACTIVE);
    #2 reset_L = 1'b0;
    #1;
    check("mid_rst_state", state, S_RESET);
    check("mid_rst_pop_push", {pop_vc0, pop_vc1, push_d0, push_d1}, 0);
    check("mid_rst_data_out", data_out, 0);
    check("mid_rst_fifo_init", fifo_init, 0);
    check("mid_rst_umbral", {umbral_vc, umbral_d}, 0);
    check("mid_rst_decodes", {idle, active, error_out}, 0);
    exp_q.delete();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
